// File: rtl/wb_grf.sv
// MIPS writeback stage: decodes the W-stage instruction into a register write
// and holds the 32x32 general register file with optional same-cycle bypass.
module wb_grf #(
    parameter int WB_BYPASS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_W,
    input  logic [31:0] PC8_W,
    input  logic [31:0] AO_W,
    input  logic [31:0] DR_W,
    input  logic [31:0] HI_W,
    input  logic [31:0] LO_W,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [4:0]  wa_W,
    output logic [31:0] wd_W,
    output logic        we_W,
    output logic [31:0] retired
);
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  dst;
    logic        has_src;
    logic [31:0] byte_shift;
    logic [31:0] half_shift;
    logic [31:0] regs_reg [32];
    logic [31:0] retired_reg;

    assign op    = IR_W[31:26];
    assign funct = IR_W[5:0];

    // Load lanes: byte offset from AO_W[1:0], halfword from AO_W[1] only.
    assign byte_shift = DR_W >> {AO_W[1:0], 3'b000};
    assign half_shift = AO_W[1] ? {16'h0000, DR_W[31:16]} : {16'h0000, DR_W[15:0]};

    always_comb begin
        dst     = 5'd0;
        has_src = 1'b0;
        wd_W    = 32'h0;
        case (op)
            6'h00: begin
                dst = IR_W[15:11];
                case (funct)
                    6'h21, 6'h23, 6'h2A, 6'h00: begin has_src = 1'b1; wd_W = AO_W;  end
                    6'h10:                      begin has_src = 1'b1; wd_W = HI_W;  end
                    6'h12:                      begin has_src = 1'b1; wd_W = LO_W;  end
                    6'h09:                      begin has_src = 1'b1; wd_W = PC8_W; end
                    default:                    dst = 5'd0;
                endcase
            end
            6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F: begin
                dst = IR_W[20:16]; has_src = 1'b1; wd_W = AO_W;
            end
            6'h23: begin dst = IR_W[20:16]; has_src = 1'b1; wd_W = DR_W; end
            6'h20: begin
                dst = IR_W[20:16]; has_src = 1'b1;
                wd_W = {{24{byte_shift[7]}}, byte_shift[7:0]};
            end
            6'h24: begin
                dst = IR_W[20:16]; has_src = 1'b1;
                wd_W = {24'h0, byte_shift[7:0]};
            end
            6'h21: begin
                dst = IR_W[20:16]; has_src = 1'b1;
                wd_W = {{16{half_shift[15]}}, half_shift[15:0]};
            end
            6'h25: begin
                dst = IR_W[20:16]; has_src = 1'b1;
                wd_W = {16'h0, half_shift[15:0]};
            end
            6'h03: begin dst = 5'd31; has_src = 1'b1; wd_W = PC8_W; end
            default: ;
        endcase
    end

    // Writes to $0 are dropped but wd_W keeps the decoded value for observability.
    assign we_W = has_src && (dst != 5'd0);
    assign wa_W = we_W ? dst : 5'd0;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                always_ff @(posedge clk) regs_reg[gi] <= 32'h0;
            end else begin : g_entry
                always_ff @(posedge clk) begin
                    if (!reset)
                        regs_reg[gi] <= 32'h0;
                    else if (we_W && wa_W == 5'(gi))
                        regs_reg[gi] <= wd_W;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset)
            retired_reg <= 32'h0;
        else if (IR_W != 32'h0)
            retired_reg <= retired_reg + 32'd1;
    end

    assign retired = retired_reg;

    assign rd1 = (ra1 == 5'd0) ? 32'h0 :
                 ((WB_BYPASS != 0) && we_W && wa_W == ra1) ? wd_W : regs_reg[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'h0 :
                 ((WB_BYPASS != 0) && we_W && wa_W == ra2) ? wd_W : regs_reg[ra2];
endmodule

// File: doc/wb_grf.md
# wb_grf

Writeback stage and general register file for the 5-stage MIPS pipeline. Consumes the MEM/WB pipeline-register contents: instruction, PC+8, ALU result, memory read word, HI and LO. Decodes the W-stage instruction into a destination register and a write value, including load byte/half extraction, and commits the value to a 32×32 register file. Serves the two D-stage read ports with optional same-cycle write-through bypass, and exports the W-stage write triple to the hazard/forwarding unit.

## Interface
Parameters:
- WB_BYPASS, 1: 1 = D-stage reads see the W-stage write in the same cycle; 0 = reads return the stored array value only.

Ports:
- clk  in  1  system clock, all state on posedge
- reset  in  1  synchronous, active-low; sampled on posedge clk
- IR_W  in  32  W-stage instruction
- PC8_W  in  32  W-stage PC+8
- AO_W  in  32  W-stage ALU result / memory address
- DR_W  in  32  W-stage memory read word, unaligned
- HI_W, LO_W  in  32 each  W-stage HI/LO values
- ra1, ra2  in  5 each  D-stage read addresses
- rd1, rd2  out  32 each  D-stage read data
- wa_W  out  5  decoded destination; 0 when no write
- wd_W  out  32  decoded write data
- we_W  out  1  write enable; 0 when wa_W would be 0
- retired  out  32  count of non-zero IR_W cycles

## Operation
- Destination and source decode. op = IR_W[31:26], funct = IR_W[5:0]:
  - op 0, funct 0x21/0x23/0x2A/0x00 (addu/subu/slt/sll): rd = IR_W[15:11], data AO_W.
  - op 0, funct 0x10 (mfhi): rd, data HI_W. Funct 0x12 (mflo): rd, data LO_W.
  - op 0, funct 0x09 (jalr): rd, data PC8_W.
  - op 0x09/0x0A/0x0C/0x0D/0x0F (addiu/slti/andi/ori/lui): rt = IR_W[20:16], data AO_W.
  - op 0x23 lw: rt, data DR_W.
  - op 0x20 lb / 0x24 lbu: rt. Data is byte DR_W[8k+7:8k] with k = AO_W[1:0], sign- or zero-extended.
  - op 0x21 lh / 0x25 lhu: rt. Data is halfword DR_W[16h+15:16h] with h = AO_W[1], sign- or zero-extended. AO_W[0] is ignored.
  - op 0x03 jal: register 31, data PC8_W.
  - All other encodings (stores, branches, j, jr, mult/div, mthi/mtlo, undefined): no write.
- Any case whose destination is 0 is forced to no write: wa_W = 0, we_W = 0.
  - wd_W still shows the decoded value in this case.
  - wd_W = 0 when no source is selected at all.
- Register file:
  - 32 entries; entry 0 reads 0 permanently.
  - At posedge with reset = 1 and we_W = 1, reg[wa_W] <= wd_W.
- Reads are combinational:
  - rd1 = (ra1 == 0) ? 0 : (WB_BYPASS && we_W && wa_W == ra1) ? wd_W : reg[ra1]. rd2 is the same with ra2.
- retired counter:
  - At posedge with reset = 1, increments by 1 when IR_W ≠ 0.
  - Wraps from 0xFFFFFFFF to 0.

## Timing
- Reset: at posedge with reset = 0, all 32 entries and retired clear to 0. No write commits on that edge, even if we_W = 1. Reset can be applied at any point and clears everything regardless of state.
- Outputs after reset: rd1 = rd2 = 0 for all addresses. retired = 0. wa_W/wd_W/we_W follow the inputs combinationally, so they read 0/0/0 when IR_W = 0.
- Decode latency: wa_W, wd_W and we_W are combinational from IR_W/AO_W/DR_W/PC8_W/HI_W/LO_W (0 cycles).
- Write latency: a value is visible in the array from the cycle after the commit edge. With WB_BYPASS = 1 it is also visible on rd1/rd2 in the commit cycle itself.
- Same address on ra1 and ra2 is legal; both ports return the same value.
- Back-to-back writes to the same register: the last one wins; each is bypassed in its own cycle.

## Test plan
- Reset: hold reset = 0 for 2 cycles with IR_W = jal and PC8_W = 0x3008 → reg[31] = 0, retired = 0. Release → next edge writes reg[31] = 0x00003008 and retired = 1.
- ALU and $0: addu $5 with AO_W = 0x1234 → rd1(ra1 = 5) = 0x1234 in the same cycle (bypass) and after. addu $0 with AO_W = 0xFFFF → we_W = 0 and rd1(ra1 = 0) = 0.
- Loads, with DR_W = 0x80FF7F01:
  - lb at AO_W[1:0] = 3 → 0xFFFFFF80.
  - lbu at offset 3 → 0x00000080.
  - lh at AO_W = 2 → 0xFFFF80FF.
  - lhu at AO_W = 0 → 0x00007F01.
- HI/LO and links: mfhi $8 with HI_W = 0xDEADBEEF → reg[8] = 0xDEADBEEF. mflo $9 with LO_W = 0x5 → reg[9] = 5. jalr $7 with PC8_W = 0x3010 → reg[7] = 0x3010.
- Non-writers: sw, beq, mult, and opcode 0x3F → we_W = 0 and the array is unchanged. With WB_BYPASS = 0, addu $3 → rd1(ra1 = 3) is the old value in the commit cycle and the new value one cycle later.
- Counter: preload retired = 0xFFFFFFFF via 2^32 − 1 non-zero cycles (or a forced state) → the next non-zero IR_W gives 0. Cycles with IR_W = 0 hold the count.
